// File: rtl/xcom_pkg.sv
// Shared constants, header layout and FSM state type for the XCOM link command responder.
package xcom_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_PING = 4'hF;

    localparam int unsigned HDR_RESP_BIT = 4;
    localparam logic [1:0]  LEN_32       = 2'b11;

    typedef enum logic {
        IDLE,
        SEND
    } resp_st_t;

    // Response header: [7] start, [6:5] length code, [4] response flag, [3:0] opcode answered.
    function automatic logic [7:0] resp_header(input logic [3:0] op);
        logic [7:0] hdr;
        hdr               = 8'h80;
        hdr[6:5]          = LEN_32;
        hdr[HDR_RESP_BIT] = 1'b1;
        hdr[3:0]          = op;
        return hdr;
    endfunction

endpackage

// File: rtl/xcom_resp_fifo.sv
// Synchronous command FIFO; a push while full is still accepted when a pop happens in the
// same cycle.
module xcom_resp_fifo #(
    parameter int unsigned AW = 2,
    parameter int unsigned W  = 36
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         push_ok_o
);

    localparam int unsigned  Depth    = 1 << AW;
    localparam logic [AW:0]  CntOne   = (AW + 1)'(1);
    localparam logic [AW:0]  CntFull  = (AW + 1)'(Depth);
    localparam logic [AW-1:0] PtrOne  = AW'(1);

    logic [W-1:0]  mem_q [Depth];
    logic [W-1:0]  mem_d [Depth];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == CntFull);
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign push_ok_o = do_push;
    assign rdata_o   = mem_q[rptr_q];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + PtrOne;
        end
        if (do_pop) begin
            rptr_d = rptr_q + PtrOne;
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntOne;
            2'b01:   cnt_d = cnt_q - CntOne;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/xcom_link_resp.sv
// XCOM link command responder: buffers received packets, strobes core commands and answers
// PING. Defining XCOM_RESP_ACK_EN makes every core command produce a response as well.
module xcom_link_resp
    import xcom_pkg::*;
#(
    parameter int unsigned FIFO_AW = 2
) (
    input  logic        x_clk_i,
    input  logic        x_rst_i,
    input  logic [3:0]  xcom_id_i,
    input  logic        clr_i,
    input  logic        rx_vld_i,
    input  logic [3:0]  rx_cmd_i,
    input  logic [31:0] rx_data_i,
    output logic        cmd_vld_o,
    output logic [3:0]  cmd_op_o,
    output logic [31:0] cmd_dt_o,
    output logic        tx_vld_o,
    input  logic        tx_rdy_i,
    output logic [7:0]  tx_header_o,
    output logic [31:0] tx_data_o,
    output logic [15:0] rx_cnt_o,
    output logic        ovf_o
);

`ifdef XCOM_RESP_ACK_EN
    localparam bit AckEn = 1'b1;
`else
    localparam bit AckEn = 1'b0;
`endif

    // Input stage register gives the two-cycle rx-to-output latency.
    logic        in_vld_q;
    logic [3:0]  in_cmd_q;
    logic [31:0] in_data_q;

    logic [35:0] head;
    logic [3:0]  head_op;
    logic [31:0] head_dt;
    logic        pop, full, empty, push_ok, is_cmd, need_resp;

    resp_st_t    state_q, state_d;
    logic        cmd_vld_q, cmd_vld_d;
    logic [3:0]  cmd_op_q, cmd_op_d;
    logic [31:0] cmd_dt_q, cmd_dt_d;
    logic [7:0]  tx_hdr_q, tx_hdr_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic        ovf_q, ovf_d;

    xcom_resp_fifo #(
        .AW (FIFO_AW),
        .W  (36)
    ) u_fifo (
        .clk_i     (x_clk_i),
        .rst_i     (x_rst_i),
        .push_i    (in_vld_q),
        .wdata_i   ({in_cmd_q, in_data_q}),
        .pop_i     (pop),
        .rdata_o   (head),
        .full_o    (full),
        .empty_o   (empty),
        .push_ok_o (push_ok)
    );

    assign head_op   = head[35:32];
    assign head_dt   = head[31:0];
    assign is_cmd    = (head_op != OP_NOP) && (head_op != OP_PING);
    assign need_resp = (head_op == OP_PING) || (AckEn && is_cmd);

    always_comb begin
        state_d   = state_q;
        cmd_vld_d = 1'b0;
        cmd_op_d  = cmd_op_q;
        cmd_dt_d  = cmd_dt_q;
        tx_hdr_d  = tx_hdr_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;

        unique case (state_q)
            IDLE: pop = !empty;
            SEND: begin
                pop = tx_rdy_i && !empty;
                if (tx_rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            if (is_cmd) begin
                cmd_vld_d = 1'b1;
                cmd_op_d  = head_op;
                cmd_dt_d  = head_dt;
            end
            if (need_resp) begin
                tx_hdr_d  = resp_header(head_op);
                tx_data_d = {xcom_id_i, 4'h0, rx_cnt_q[7:0], head_dt[15:0]};
                state_d   = SEND;
            end
        end

        // A push coinciding with clr_i leaves the counter at one.
        rx_cnt_d = clr_i ? 16'd0 : rx_cnt_q;
        if (push_ok) begin
            rx_cnt_d = rx_cnt_d + 16'd1;
        end
        ovf_d = (ovf_q && !clr_i) || (in_vld_q && !push_ok);
    end

    always_ff @(posedge x_clk_i) begin
        if (x_rst_i) begin
            in_vld_q  <= 1'b0;
            in_cmd_q  <= 4'h0;
            in_data_q <= 32'h0;
            state_q   <= IDLE;
            cmd_vld_q <= 1'b0;
            cmd_op_q  <= 4'h0;
            cmd_dt_q  <= 32'h0;
            tx_hdr_q  <= 8'h0;
            tx_data_q <= 32'h0;
            rx_cnt_q  <= 16'h0;
            ovf_q     <= 1'b0;
        end else begin
            in_vld_q  <= rx_vld_i;
            in_cmd_q  <= rx_cmd_i;
            in_data_q <= rx_data_i;
            state_q   <= state_d;
            cmd_vld_q <= cmd_vld_d;
            cmd_op_q  <= cmd_op_d;
            cmd_dt_q  <= cmd_dt_d;
            tx_hdr_q  <= tx_hdr_d;
            tx_data_q <= tx_data_d;
            rx_cnt_q  <= rx_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign cmd_vld_o   = cmd_vld_q;
    assign cmd_op_o    = cmd_op_q;
    assign cmd_dt_o    = cmd_dt_q;
    assign tx_vld_o    = (state_q == SEND);
    assign tx_header_o = tx_hdr_q;
    assign tx_data_o   = tx_data_q;
    assign rx_cnt_o    = rx_cnt_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_xcom_link_resp.sv
// Scoreboard bench for xcom_link_resp: stimulus pushes expected responses/commands into
// queues, a negedge monitor pops and compares whenever the DUT presents them.
module tb_xcom_link_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  id = 4'hA;
    logic        rx_vld = 1'b0;
    logic [3:0]  rx_cmd = 4'h0;
    logic [31:0] rx_data = 32'h0;
    logic        tx_rdy = 1'b0;
    logic        cmd_vld, tx_vld, ovf;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_dt, tx_data;
    logic [7:0]  tx_header;
    logic [15:0] rx_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [39:0] tx_q[$];
    logic [35:0] cmd_q[$];

    xcom_link_resp #(
        .FIFO_AW (2)
    ) dut (
        .x_clk_i     (clk),
        .x_rst_i     (rst),
        .xcom_id_i   (id),
        .clr_i       (clr),
        .rx_vld_i    (rx_vld),
        .rx_cmd_i    (rx_cmd),
        .rx_data_i   (rx_data),
        .cmd_vld_o   (cmd_vld),
        .cmd_op_o    (cmd_op),
        .cmd_dt_o    (cmd_dt),
        .tx_vld_o    (tx_vld),
        .tx_rdy_i    (tx_rdy),
        .tx_header_o (tx_header),
        .tx_data_o   (tx_data),
        .rx_cnt_o    (rx_cnt),
        .ovf_o       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges, then step just past the edge before driving inputs.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] dt);
        rx_vld  = 1'b1;
        rx_cmd  = op;
        rx_data = dt;
        tick(1);
        rx_vld  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tx_q.delete();
        cmd_q.delete();
        tick(2);
        rst = 1'b0;
    endtask

    function automatic logic [39:0] resp(input logic [3:0] op, input logic [7:0] cnt,
                                         input logic [15:0] dt);
        return {4'hF, op, id, 4'h0, cnt, dt};
    endfunction

    task automatic exp_cmd(input logic [3:0] op, input logic [31:0] dt, input logic [7:0] cnt);
        cmd_q.push_back({op, dt});
`ifdef XCOM_RESP_ACK_EN
        tx_q.push_back(resp(op, cnt, dt[15:0]));
`else
        if (cnt == 8'hFF) $display("note: cnt %0d", cnt);
`endif
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_vld) begin
                if (tx_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got %0h %0h, expected no response",
                             tx_header, tx_data);
                end else if (tx_rdy) begin
                    chk("tx_resp", {tx_header, tx_data}, tx_q.pop_front());
                end else begin
                    chk("tx_hold", {tx_header, tx_data}, tx_q[0]);
                end
            end
            if (cmd_vld) begin
                if (cmd_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL cmd_unexpected: got %0h %0h, expected no strobe",
                             cmd_op, cmd_dt);
                end else begin
                    chk("cmd", {4'h0, cmd_op, cmd_dt}, {4'h0, cmd_q.pop_front()});
                end
            end
        end
    end

    initial begin
        // Reset values
        tick(3);
        chk("rst_tx_vld", 40'(tx_vld), 40'h0);
        chk("rst_tx_hdr", 40'(tx_header), 40'h0);
        chk("rst_tx_data", 40'(tx_data), 40'h0);
        chk("rst_cmd", {3'b0, cmd_vld, cmd_op, cmd_dt}, 40'h0);
        chk("rst_cnt_ovf", {23'h0, ovf, rx_cnt}, 40'h0);
        rst = 1'b0;

        // Single PING with latency check
        tx_rdy = 1'b1;
        tx_q.push_back(resp(4'hF, 8'h01, 16'h1234));
        send(4'hF, 32'h0000_1234);
        @(negedge clk);
        chk("lat_0", 40'(tx_vld), 40'h0);
        @(negedge clk);
        chk("lat_1", 40'(tx_vld), 40'h0);
        @(negedge clk);
        chk("lat_2", 40'(tx_vld), 40'h1);
        @(negedge clk);
        chk("lat_3", 40'(tx_vld), 40'h0);
        tick(1);
        chk("ping_cnt", 40'(rx_cnt), 40'h1);
        chk("ping_drain", 40'(tx_q.size()), 40'h0);

        // Back-to-back core commands
        do_reset();
        exp_cmd(4'h3, 32'd16, 8'h01);
        exp_cmd(4'h5, 32'hAAAA_5555, 8'h02);
        exp_cmd(4'h7, 32'h1357_9BDF, 8'h03);
        exp_cmd(4'h1, 32'hDEAD_BEEF, 8'h04);
        send(4'h3, 32'd16);
        send(4'h5, 32'hAAAA_5555);
        send(4'h7, 32'h1357_9BDF);
        send(4'h1, 32'hDEAD_BEEF);
        tick(8);
        chk("cmd_drain", 40'(cmd_q.size() + tx_q.size()), 40'h0);
        chk("cmd_hold", {4'h0, cmd_op, cmd_dt}, {8'h01, 32'hDEAD_BEEF});

        // Stalled transmitter: responses held, then released back-to-back.
        // Counter byte is sampled at pop; PINGs 2 and 3 pop after all three were counted.
        do_reset();
        tx_rdy = 1'b0;
        tx_q.push_back(resp(4'hF, 8'h01, 16'h0001));
        tx_q.push_back(resp(4'hF, 8'h03, 16'h0002));
        tx_q.push_back(resp(4'hF, 8'h03, 16'h0003));
        send(4'hF, 32'h0000_0001);
        send(4'hF, 32'h0000_0002);
        send(4'hF, 32'h0000_0003);
        tick(20);
        chk("stall_vld", 40'(tx_vld), 40'h1);
        tx_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_vld", 40'(tx_vld), 40'h1);
        end
        @(negedge clk);
        chk("b2b_end", 40'(tx_vld), 40'h0);
        tick(1);
        chk("stall_drain", 40'(tx_q.size()), 40'h0);

        // Overflow: one in SEND, four stored, sixth dropped
        do_reset();
        tx_rdy = 1'b0;
        tx_q.push_back(resp(4'hF, 8'h01, 16'h0010));
        for (int i = 1; i < 5; i++) tx_q.push_back(resp(4'hF, 8'h05, 16'(16'h0010 + i)));
        for (int i = 0; i < 6; i++) send(4'hF, 32'(32'h10 + i));
        tick(4);
        chk("ovf_set", 40'(ovf), 40'h1);
        chk("ovf_cnt", 40'(rx_cnt), 40'd5);
        tx_rdy = 1'b1;
        tick(8);
        chk("ovf_drain", 40'(tx_q.size()), 40'h0);
        chk("ovf_sticky", 40'(ovf), 40'h1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_ovf", 40'(ovf), 40'h0);
        chk("clr_cnt", 40'(rx_cnt), 40'h0);

        // NOPs: counted, no activity; then counter wrap
        do_reset();
        for (int i = 0; i < 3; i++) send(4'h0, 32'(i));
        tick(4);
        chk("nop_cnt", 40'(rx_cnt), 40'd3);
        do_reset();
        rx_cmd = 4'h0;
        rx_vld = 1'b1;
        tick(65535);
        rx_vld = 1'b0;
        tick(2);
        chk("wrap_ffff", 40'(rx_cnt), 40'hFFFF);
        send(4'h0, 32'h0);
        tick(2);
        chk("wrap_zero", 40'(rx_cnt), 40'h0);
        chk("wrap_ovf", 40'(ovf), 40'h0);

        // Reset while in SEND
        do_reset();
        tx_rdy = 1'b0;
        tx_q.push_back(resp(4'hF, 8'h01, 16'h0077));
        send(4'hF, 32'h0000_0077);
        tick(5);
        chk("send_vld", 40'(tx_vld), 40'h1);
        rst = 1'b1;
        tx_q.delete();
        tick(1);
        chk("mid_rst_tx", {tx_vld, tx_header, tx_data[30:0]}, 40'h0);
        chk("mid_rst_misc", {cmd_vld, ovf, cmd_op, rx_cnt, 2'b0, tx_data[31]}, 24'h0);
        rst = 1'b0;
        tx_rdy = 1'b1;
        tx_q.push_back(resp(4'hF, 8'h01, 16'h0055));
        send(4'hF, 32'h0000_0055);
        tick(6);
        chk("post_rst_drain", 40'(tx_q.size()), 40'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
